fetch_issue_buffer: RTL and testbench

- Parametrised elastic buffer between Fetch and Issue; successor to the single-entry IF/Issue register.
- Holds DEPTH entries of WIDTH-bit fetch payload with valid/ready handshakes on both sides.
- Adds a synchronous flush for branch mispredict and occupancy reporting.
- Issue-side stalls absorb into the buffer instead of dropping or overwriting data.

---
 rtl/fetch_issue_buffer.sv | 122 ++++++++++++
 tb/tb_fetch_issue_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer
//   Elastic FIFO between Fetch and Issue. It holds DEPTH entries of WIDTH-bit
//   payload and uses valid/ready handshakes on both sides. A synchronous flush
//   discards all entries, for example on a branch mispredict. Issue-side
//   stalls are absorbed into the storage, so no payload is dropped or
//   overwritten.
//
//   Optional feature: define FIB_BYPASS_EN for a zero-latency bypass while the
//   buffer is empty. A payload offered to an empty buffer then appears on
//   out_* in the same cycle. If Issue takes it in that cycle, it is never
//   written into the storage.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   flush      synchronous flush; has priority over push and pop
//   in_valid   fetch presents in_data
//   in_data    fetch payload
//   in_ready   buffer accepts a payload this cycle (!full && !flush)
//   out_valid  head entry is valid for issue
//   out_data   head payload
//   out_ready  issue consumes the head this cycle
//   count      number of stored entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
`timescale 1ns/1ps

module fetch_issue_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic             wr_en, rd_en;

  // DEPTH need not be a power of two, so the pointer wraps explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // in_ready does not look at out_ready. A full buffer never accepts a
  // payload, even when the head is popped in the same cycle.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef FIB_BYPASS_EN
  always_comb begin
    out_valid = !flush && (empty ? in_valid : 1'b1);
    out_data  = empty ? in_data : mem_q[rd_ptr_q];
  end
  // When empty, a pop can only be the bypassed payload. Skip the write so
  // that count stays 0.
  assign wr_en = push && !(empty && out_ready);
  assign rd_en = pop && !empty;
`else
  assign out_valid = !empty && !flush;
  assign out_data  = mem_q[rd_ptr_q];
  assign wr_en     = push;
  assign rd_en     = pop;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage has no reset; its contents are only read while out_valid=1.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// tb_fetch_issue_buffer
//   Scoreboard bench for fetch_issue_buffer.
//   The driver keeps a queue of accepted payloads as the reference model. It
//   derives the expected handshake and occupancy values from the queue size.
//   A separate monitor checks the outputs every cycle and pops the queue
//   whenever the DUT presents a consumed head.
`timescale 1ns/1ps

module tb_fetch_issue_buffer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  fetch_issue_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  logic [WIDTH-1:0] sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;
  int  exp_count;
  bit  exp_in_ready;
  bit  exp_out_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and update the reference queue. The new
  // inputs take effect at the next rising edge.
  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit rdy, input bit fl);
    int sz;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    sz = sb.size();
    exp_count    = sz;
    exp_in_ready = (sz < DEPTH) && !fl;
`ifdef FIB_BYPASS_EN
    exp_out_valid = !fl && ((sz > 0) || v);
`else
    exp_out_valid = !fl && (sz > 0);
`endif
    if (fl) sb.delete();
    else if (v && exp_in_ready) sb.push_back(d);
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("count",     64'(count),     64'(exp_count));
      check("in_ready",  64'(in_ready),  64'(exp_in_ready));
      check("out_valid", 64'(out_valid), 64'(exp_out_valid));
      check("full",      64'(full),      64'(exp_count == DEPTH));
      check("empty",     64'(empty),     64'(exp_count == 0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("pop_with_nothing_expected", 64'd1, 64'd0);
        else check("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},     64'(count),     64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_empty"},     64'(empty),     64'd1);
    check({tag, "_full"},      64'(full),      64'd0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;

    // Async reset in the middle of a stream, with three entries held
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(16'h30 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_state("async_rst");
    sb.delete();
    @(negedge clk);
    check_reset_state("rst_held");
    reset = 1'b1;
    drive(1'b1, WIDTH'(16'hA5), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to full under backpressure; 5 is held and refused while full
    for (int i = 1; i <= 4; i++) drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(5), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(5), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(5), 1'b1, 1'b0);
    drive(1'b1, WIDTH'(5), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // Continuous push and pop at count 2, wrapping both pointers
    drive(1'b1, WIDTH'(16'h10), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(16'h11), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, WIDTH'(16'h12 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // Flush at count 3 with a competing push of 0xFF
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(16'h40 + i), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(16'hFF), 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop with count at DEPTH-1
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(16'h50 + i), 1'b0, 1'b0);
    drive(1'b1, WIDTH'(16'h53), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 9) < 7, WIDTH'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 39) == 0);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
    check("final_queue_drained", 64'(sb.size()), 64'd0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
